data_sync_tx: RTL and testbench



---
 rtl/data_sync_tx_pkg.sv | 14 +
 rtl/data_sync_tx.sv | 79 +++++++
 tb/tb_data_sync_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/data_sync_tx_pkg.sv
// data_sync_tx_pkg: state encoding, default hold/gap lengths and counter sizing
// shared by the launcher and the integration level.
package data_sync_tx_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_GAP_CYCLES  = 4;

    function automatic int cnt_width(input int hold, input int gap);
        return $clog2((hold > gap ? hold : gap) + 1);
    endfunction

endpackage

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-domain launcher presenting a stable word and a level enable
// (held HOLD_CYCLES, then low GAP_CYCLES) to a destination multi-flop synchronizer.
module data_sync_tx
    import data_sync_tx_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
        end
    end

    // Transitions happen at count zero, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        en_d    = en_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = HOLD;
                bus_d   = in_data;
                en_d    = 1'b1;
                cnt_d   = CW'(HOLD_CYCLES - 1);
            end
            HOLD: if (cnt_q == '0) begin
                state_d = GAP;
                en_d    = 1'b0;
                cnt_d   = CW'(GAP_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            GAP: if (cnt_q == '0) state_d = IDLE;
                 else cnt_d = cnt_q - CW'(1);
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = state_q == IDLE;
        busy     = state_q != IDLE;
    end

    assign unsync_bus = bus_q;
    assign bus_enable = en_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed checks of the launcher at default and minimum hold/gap,
// plus an end-to-end run through a behavioural 2-stage destination synchronizer.
module tb_data_sync_tx;

    logic       CLK = 1'b0;
    logic       DCLK = 1'b0;
    logic       RST;
    logic [7:0] in_data, in_data1;
    logic       in_valid, in_valid1;
    logic       in_ready, bus_enable, busy;
    logic       in_ready1, bus_enable1, busy1;
    logic [7:0] unsync_bus, unsync_bus1;

    int checks = 0;
    int failures = 0;

    always #15 CLK = ~CLK;
    always #5 DCLK = ~DCLK;

    data_sync_tx u_dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy)
    );

    data_sync_tx #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_min (
        .CLK(CLK), .RST(RST), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .unsync_bus(unsync_bus1), .bus_enable(bus_enable1), .busy(busy1)
    );

    // Destination side: two sync flops plus an edge-detect flop; data captured on the pulse.
    logic [2:0] s_q;
    logic [7:0] rx_q[$];
    always @(posedge DCLK or negedge RST) begin
        if (!RST) s_q <= '0;
        else begin
            s_q <= {s_q[1:0], bus_enable};
            if (s_q[1] && !s_q[2]) rx_q.push_back(unsync_bus);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic xfer(input logic [7:0] d, input bit poke);
        in_data = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_en", bus_enable, 1);
            chk("hold_bus", unsync_bus, d);
            chk("hold_rdy", in_ready, 0);
            if (poke && i == 1) begin in_data = 8'hFF; in_valid = 1'b1; end
            step();
            in_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            chk("gap_en", bus_enable, 0);
            chk("gap_bus", unsync_bus, d);
            chk("gap_busy", busy, 1);
            step();
        end
        chk("idle_rdy", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_bus", unsync_bus, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] words[3];
        logic [7:0] exp_q[$];
        logic [7:0] w;
        int nacc, last_acc, rises;
        logic rdy_prev, en_prev;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        #2 RST = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_bus", unsync_bus, 0);
        chk("rst_en", bus_enable, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_busy", busy, 0);
        RST = 1'b1;
        step(); step();
        chk("post_rst_en", bus_enable, 0);
        chk("post_rst_rdy", in_ready, 1);

        xfer(8'hA5, 1'b0);

        // Back-to-back: in_valid stays high, data advances on each accept.
        nacc = 0; last_acc = 0; rises = 0; en_prev = bus_enable;
        in_data = words[0]; in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rdy_prev = in_ready;
            step();
            if (bus_enable && !en_prev) rises++;
            en_prev = bus_enable;
            if (rdy_prev && in_valid) begin
                chk("b2b_bus", unsync_bus, words[nacc]);
                if (nacc > 0) chk("b2b_spacing", c - last_acc, 9);
                last_acc = c;
                nacc++;
                if (nacc < 3) in_data = words[nacc];
                else in_valid = 1'b0;
            end else if (nacc > 0) begin
                chk("b2b_stable", unsync_bus, words[nacc-1]);
            end
        end
        chk("b2b_accepts", nacc, 3);
        chk("b2b_rises", rises, 3);

        xfer(8'h3C, 1'b1);

        // Minimum hold/gap instance: accepts three cycles apart, enable 1,0,0.
        in_data1 = 8'h01; in_valid1 = 1'b1;
        step();
        chk("min_en0", bus_enable1, 1);
        chk("min_bus0", unsync_bus1, 8'h01);
        in_data1 = 8'h02;
        step();
        chk("min_en1", bus_enable1, 0);
        chk("min_rdy1", in_ready1, 0);
        step();
        chk("min_en2", bus_enable1, 0);
        chk("min_rdy2", in_ready1, 1);
        chk("min_bus2", unsync_bus1, 8'h01);
        step();
        in_valid1 = 1'b0;
        chk("min_en3", bus_enable1, 1);
        chk("min_bus3", unsync_bus1, 8'h02);
        step();
        chk("min_en4", bus_enable1, 0);
        step();
        chk("min_en5", bus_enable1, 0);
        chk("min_rdy5", in_ready1, 1);

        // Reset in the second HOLD cycle takes effect without a clock edge.
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_en_before", bus_enable, 1);
        #2 RST = 1'b0;
        #1;
        chk("mid_en_async", bus_enable, 0);
        chk("mid_bus_async", unsync_bus, 0);
        chk("mid_busy_async", busy, 0);
        step();
        RST = 1'b1;
        step();
        chk("mid_rdy", in_ready, 1);
        chk("mid_en", bus_enable, 0);
        xfer(8'h77, 1'b0);

        // End-to-end through the destination synchronizer.
        step();
        rx_q.delete();
        for (int k = 0; k < 16; k++) begin
            w = 8'($urandom);
            exp_q.push_back(w);
            chk("e2e_rdy", in_ready, 1);
            in_data = w; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int j = 0; j < 8; j++) step();
        end
        for (int j = 0; j < 4; j++) step();
        chk("e2e_count", rx_q.size(), 16);
        for (int k = 0; k < 16; k++)
            chk("e2e_word", k < rx_q.size() ? {24'd0, rx_q[k]} : 32'hDEAD, {24'd0, exp_q[k]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
